// File: rtl/fast_win_pkg.sv
// Shared types and helpers for the FAST sliding-window generator.
package fast_win_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACTIVE
  } state_e;

  localparam int COORD_W = 10;

  function automatic int half_patch(input int patch_size);
    return (patch_size - 1) / 2;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Single-port read-first line buffer: one word per column holds every history line,
// so a single read returns the whole vertical strip above the incoming pixel.
module line_buf_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 48,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Asynchronous read returns the pre-write contents within the accepting cycle.
  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/fast_win_gen.sv
// Sliding PATCH_SIZE x PATCH_SIZE window generator for the FAST front end.
// Define FAST_WIN_COORD_EN to add the ctr_x/ctr_y centre-coordinate outputs.
module fast_win_gen
  import fast_win_pkg::*;
#(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int PATCH_SIZE  = 7,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ce,
  input  logic [PIXEL_WIDTH-1:0]                        in_data,
  input  logic                                          in_vld,
  input  logic                                          in_sof,
  output logic [PATCH_SIZE*PATCH_SIZE*PIXEL_WIDTH-1:0]  win_data,
  output logic                                          win_vld,
`ifdef FAST_WIN_COORD_EN
  output logic [COORD_W-1:0]                            ctr_x,
  output logic [COORD_W-1:0]                            ctr_y,
`endif
  output logic                                          frm_done,
  output logic                                          sof_err
);

  localparam int P    = PATCH_SIZE;
  localparam int PW   = PIXEL_WIDTH;
  localparam int AW   = $clog2(COL_NUM);
  localparam int LB_W = (P - 1) * PW;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUM - 1);
  localparam logic [COORD_W-1:0] EDGE   = COORD_W'(P - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [P*P*PW-1:0]  win_q, win_d;
  logic               vld_q, vld_d, done_q, done_d, err_q, err_d;
  logic               take, restart, last_px, win_ok;
  logic [LB_W-1:0]    lb_rdata, lb_wdata;

`ifdef FAST_WIN_COORD_EN
  localparam logic [COORD_W-1:0] HALF = COORD_W'(half_patch(P));
  logic [COORD_W-1:0] ctr_x_q, ctr_x_d, ctr_y_q, ctr_y_d;
`endif

  line_buf_ram #(
    .DEPTH(COL_NUM),
    .WIDTH(LB_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (take & ~rst),
    .addr (cur_x[AW-1:0]),
    .wdata(lb_wdata),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FAST_WIN_COORD_EN
      ctr_x_q <= '0;
      ctr_y_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FAST_WIN_COORD_EN
      ctr_x_q <= ctr_x_d;
      ctr_y_q <= ctr_y_d;
`endif
    end
  end

  // A restart or a fresh frame forces the accepted pixel to (0,0) regardless of the counters.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    restart = 1'b0;
    last_px = 1'b0;
    if (ce && in_vld) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            take    = 1'b1;
            state_d = FILL;
          end
        end
        FILL, ACTIVE: begin
          take = 1'b1;
          if (in_sof && (x_q != '0 || y_q != '0)) begin
            restart = 1'b1;
            state_d = FILL;
          end else if (state_q == FILL && y_q == EDGE) begin
            state_d = ACTIVE;
          end else if (state_q == ACTIVE && x_q == X_LAST && y_q == Y_LAST) begin
            last_px = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    cur_x  = (state_q == IDLE || restart) ? '0 : x_q;
    cur_y  = (state_q == IDLE || restart) ? '0 : y_q;
    win_ok = (cur_x >= EDGE) && (cur_y >= EDGE);
  end

  always_comb begin
    lb_wdata = {in_data, lb_rdata[LB_W-1:PW]};
    x_d      = x_q;
    y_d      = y_q;
    win_d    = win_q;
    vld_d    = vld_q;
    done_d   = done_q;
    err_d    = err_q;
`ifdef FAST_WIN_COORD_EN
    ctr_x_d  = ctr_x_q;
    ctr_y_d  = ctr_y_q;
`endif
    if (ce) begin
      vld_d  = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (take) begin
      for (int r = 0; r < P; r++) begin
        for (int c = 0; c < P - 1; c++) begin
          win_d[(r*P+c)*PW +: PW] = win_q[(r*P+c+1)*PW +: PW];
        end
      end
      for (int r = 0; r < P - 1; r++) begin
        win_d[(r*P+P-1)*PW +: PW] = lb_rdata[r*PW +: PW];
      end
      win_d[((P-1)*P+P-1)*PW +: PW] = in_data;
      vld_d  = win_ok;
      done_d = last_px;
      err_d  = restart;
      if (last_px) begin
        x_d = '0;
        y_d = '0;
      end else if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = cur_y + COORD_W'(1);
      end else begin
        x_d = cur_x + COORD_W'(1);
        y_d = cur_y;
      end
`ifdef FAST_WIN_COORD_EN
      if (win_ok) begin
        ctr_x_d = cur_x - HALF;
        ctr_y_d = cur_y - HALF;
      end
`endif
    end
  end

  assign win_data = win_q;
  assign win_vld  = vld_q;
  assign frm_done = done_q;
  assign sof_err  = err_q;
`ifdef FAST_WIN_COORD_EN
  assign ctr_x    = ctr_x_q;
  assign ctr_y    = ctr_y_q;
`endif

endmodule

// File: tb/tb_fast_win_gen.sv
// Self-checking bench for fast_win_gen: three DUTs (PATCH_SIZE 7, 3, 9) share one
// stimulus stream and are compared against an image-based reference model.
module tb_fast_win_gen;

   localparam int COLS = 16;
   localparam int ROWS = 12;

   logic clk = 1'b0;
   logic rst, ce, in_vld, in_sof;
   logic [7:0] in_data;
   logic [391:0] win7;
   logic [71:0] win3;
   logic [647:0] win9;
   logic vld7, vld3, vld9, done7, done3, done9, err7, err3, err9;
`ifdef FAST_WIN_COORD_EN
   logic [9:0] cx7, cy7, cx3, cy3, cx9, cy9;
`endif

   int n_pass = 0;
   int n_total = 0;

   // Reference model: the frame as an image plus the expected outputs per DUT (0:P7, 1:P3, 2:P9).
   bit m_in_frame = 1'b0;
   int m_x = 0;
   int m_y = 0;
   int img [ROWS][COLS];
   logic [2:0] exp_vld;
   bit exp_done, exp_err;
   logic [647:0] exp_win [3];
   bit win_known [3];
   int exp_cx [3];
   int exp_cy [3];

   always #5 clk = ~clk;

   fast_win_gen #(.COL_NUM(COLS), .ROW_NUM(ROWS), .PATCH_SIZE(7), .PIXEL_WIDTH(8)) dut7 (
      .clk(clk), .rst(rst), .ce(ce), .in_data(in_data), .in_vld(in_vld), .in_sof(in_sof),
      .win_data(win7), .win_vld(vld7),
`ifdef FAST_WIN_COORD_EN
      .ctr_x(cx7), .ctr_y(cy7),
`endif
      .frm_done(done7), .sof_err(err7));

   fast_win_gen #(.COL_NUM(COLS), .ROW_NUM(ROWS), .PATCH_SIZE(3), .PIXEL_WIDTH(8)) dut3 (
      .clk(clk), .rst(rst), .ce(ce), .in_data(in_data), .in_vld(in_vld), .in_sof(in_sof),
      .win_data(win3), .win_vld(vld3),
`ifdef FAST_WIN_COORD_EN
      .ctr_x(cx3), .ctr_y(cy3),
`endif
      .frm_done(done3), .sof_err(err3));

   fast_win_gen #(.COL_NUM(COLS), .ROW_NUM(ROWS), .PATCH_SIZE(9), .PIXEL_WIDTH(8)) dut9 (
      .clk(clk), .rst(rst), .ce(ce), .in_data(in_data), .in_vld(in_vld), .in_sof(in_sof),
      .win_data(win9), .win_vld(vld9),
`ifdef FAST_WIN_COORD_EN
      .ctr_x(cx9), .ctr_y(cy9),
`endif
      .frm_done(done9), .sof_err(err9));

   function automatic int psz(input int k);
      return (k == 0) ? 7 : ((k == 1) ? 3 : 9);
   endfunction

   // Window centred on the stored image: row 0 is the oldest line, column 0 the oldest pixel.
   function automatic logic [647:0] ref_window(input int p, input int px, input int py);
      logic [647:0] w = '0;
      for (int r = 0; r < p; r++)
         for (int c = 0; c < p; c++)
            w[(r*p+c)*8 +: 8] = 8'(img[py-p+1+r][px-p+1+c]);
      return w;
   endfunction

   task automatic model_step(input bit c_e, input bit v, input bit s, input bit r, input logic [7:0] d);
      int px, py, p;
      if (r) begin
         m_in_frame = 1'b0; m_x = 0; m_y = 0;
         exp_vld = '0; exp_done = 1'b0; exp_err = 1'b0;
         for (int k = 0; k < 3; k++) begin
            exp_win[k] = '0; win_known[k] = 1'b1; exp_cx[k] = 0; exp_cy[k] = 0;
         end
         return;
      end
      if (!c_e) return;
      exp_vld = '0; exp_done = 1'b0; exp_err = 1'b0;
      if (!v || (!m_in_frame && !s)) return;
      if (!m_in_frame) begin
         px = 0; py = 0; m_in_frame = 1'b1;
      end else if (s && (m_x != 0 || m_y != 0)) begin
         px = 0; py = 0; exp_err = 1'b1;
      end else begin
         px = m_x; py = m_y;
      end
      img[py][px] = int'(d);
      for (int k = 0; k < 3; k++) begin
         p = psz(k);
         if (px >= p - 1 && py >= p - 1) begin
            exp_vld[k] = 1'b1;
            exp_win[k] = ref_window(p, px, py);
            win_known[k] = 1'b1;
            exp_cx[k] = px - (p - 1) / 2;
            exp_cy[k] = py - (p - 1) / 2;
         end else begin
            win_known[k] = 1'b0;
         end
      end
      if (px == COLS - 1 && py == ROWS - 1) begin
         exp_done = 1'b1; m_in_frame = 1'b0; m_x = 0; m_y = 0;
      end else if (px == COLS - 1) begin
         m_x = 0; m_y = py + 1;
      end else begin
         m_x = px + 1; m_y = py;
      end
   endtask

   // Drive one cycle of inputs, advance the model, and land #1 after the sampling edge.
   task automatic apply_stimulus(input bit c_e, input bit v, input bit s, input bit r, input logic [7:0] d);
      ce = c_e; in_vld = v; in_sof = s; rst = r; in_data = d;
      model_step(c_e, v, s, r, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom));
      n_total++;
      if ({vld9, vld3, vld7, done9, done3, done7, err9, err3, err7} !== 9'b0)
         $display("[TB] FAIL reset_flags: got %b want 0", {vld9, vld3, vld7, done9, done3, done7, err9, err3, err7});
      else n_pass++;
      n_total++;
      if ({win9, win3, win7} !== '0) $display("[TB] FAIL reset_win: got nonzero window, want 0");
      else n_pass++;
`ifdef FAST_WIN_COORD_EN
      n_total++;
      if ({cx7, cy7, cx3, cy3, cx9, cy9} !== 60'b0) $display("[TB] FAIL reset_ctr: got %h want 0", {cx7, cy7, cx3, cy3, cx9, cy9});
      else n_pass++;
`endif
   endtask

   task automatic test_nominal();
      int cnt [3] = '{0, 0, 0};
      int fx [3] = '{-1, -1, -1};
      int fy [3] = '{-1, -1, -1};
      logic [2:0] seen;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            apply_stimulus(1'b1, 1'b1, (x == 0 && y == 0), 1'b0, 8'((y * 16 + x) % 256));
            n_total++;
            if ({vld9, vld3, vld7} !== exp_vld) $display("[TB] FAIL nom_vld (%0d,%0d): got %b want %b", x, y, {vld9, vld3, vld7}, exp_vld);
            else n_pass++;
            n_total++;
            if ({done9, done3, done7, err9, err3, err7} !== {{3{exp_done}}, {3{exp_err}}})
               $display("[TB] FAIL nom_pulse (%0d,%0d): got %b want %b", x, y, {done9, done3, done7, err9, err3, err7}, {{3{exp_done}}, {3{exp_err}}});
            else n_pass++;
            if (win_known[0]) begin
               n_total++;
               if (win7 !== exp_win[0][391:0]) $display("[TB] FAIL nom_win7 (%0d,%0d): got %h want %h", x, y, win7, exp_win[0][391:0]);
               else n_pass++;
            end
            if (win_known[1]) begin
               n_total++;
               if (win3 !== exp_win[1][71:0]) $display("[TB] FAIL nom_win3 (%0d,%0d): got %h want %h", x, y, win3, exp_win[1][71:0]);
               else n_pass++;
            end
            if (win_known[2]) begin
               n_total++;
               if (win9 !== exp_win[2]) $display("[TB] FAIL nom_win9 (%0d,%0d): got %h want %h", x, y, win9, exp_win[2]);
               else n_pass++;
            end
`ifdef FAST_WIN_COORD_EN
            n_total++;
            if ({cx7, cy7, cx3, cy3, cx9, cy9} !== {10'(exp_cx[0]), 10'(exp_cy[0]), 10'(exp_cx[1]), 10'(exp_cy[1]), 10'(exp_cx[2]), 10'(exp_cy[2])})
               $display("[TB] FAIL nom_ctr (%0d,%0d): got %h", x, y, {cx7, cy7, cx3, cy3, cx9, cy9});
            else n_pass++;
`endif
            if (x == 6 && y == 6) begin
               n_total++;
               if ({vld7, win7[7:0], win7[48*8 +: 8]} !== {1'b1, 8'h00, 8'h66})
                  $display("[TB] FAIL first_win7: got vld=%b e00=%h e66=%h want 1 00 66", vld7, win7[7:0], win7[48*8 +: 8]);
               else n_pass++;
            end
            if (x == 6 && y == 7) begin
               n_total++;
               if ({vld7, win7[7:0]} !== {1'b1, 8'h10}) $display("[TB] FAIL row7_win7: got vld=%b e00=%h want 1 10", vld7, win7[7:0]);
               else n_pass++;
            end
            if (x < 6 && y >= 6) begin
               n_total++;
               if (vld7 !== 1'b0) $display("[TB] FAIL wrap_gate (%0d,%0d): got %b want 0", x, y, vld7);
               else n_pass++;
            end
            seen = {vld9, vld3, vld7};
            for (int k = 0; k < 3; k++) begin
               if (seen[k] === 1'b1) begin
                  cnt[k]++;
                  if (fx[k] < 0) begin fx[k] = x; fy[k] = y; end
               end
            end
         end
      end
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      n_total++;
      if ({done7, vld7} !== 2'b00) $display("[TB] FAIL post_frame: got done=%b vld=%b want 0 0", done7, vld7);
      else n_pass++;
      n_total++;
      if ({cnt[0], cnt[1], cnt[2]} !== {32'd60, 32'd140, 32'd32})
         $display("[TB] FAIL valid_count: got %0d/%0d/%0d want 60/140/32", cnt[0], cnt[1], cnt[2]);
      else n_pass++;
      n_total++;
      if ({fx[0], fy[0], fx[1], fy[1], fx[2], fy[2]} !== {32'd6, 32'd6, 32'd2, 32'd2, 32'd8, 32'd8})
         $display("[TB] FAIL first_pos: got (%0d,%0d) (%0d,%0d) (%0d,%0d) want (6,6) (2,2) (8,8)", fx[0], fy[0], fx[1], fy[1], fx[2], fy[2]);
      else n_pass++;
   endtask

   task automatic test_bubbles();
      int sent = 0;
      int cnt = 0;
      bit v;
      for (int i = 0; i < 2000 && sent < COLS * ROWS; i++) begin
         v = 1'($urandom);
         apply_stimulus(1'b1, v, v && (sent == 0), 1'b0, 8'(sent));
         if (v) sent++;
         n_total++;
         if ({vld9, vld3, vld7} !== exp_vld) $display("[TB] FAIL bub_vld step %0d: got %b want %b", i, {vld9, vld3, vld7}, exp_vld);
         else n_pass++;
         n_total++;
         if ({done7, err7} !== {exp_done, exp_err}) $display("[TB] FAIL bub_pulse step %0d: got %b want %b", i, {done7, err7}, {exp_done, exp_err});
         else n_pass++;
         if (win_known[0]) begin
            n_total++;
            if (win7 !== exp_win[0][391:0]) $display("[TB] FAIL bub_win7 step %0d: got %h want %h", i, win7, exp_win[0][391:0]);
            else n_pass++;
         end
         if (win_known[2]) begin
            n_total++;
            if (win9 !== exp_win[2]) $display("[TB] FAIL bub_win9 step %0d: got %h want %h", i, win9, exp_win[2]);
            else n_pass++;
         end
`ifdef FAST_WIN_COORD_EN
         n_total++;
         if ({cx7, cy7} !== {10'(exp_cx[0]), 10'(exp_cy[0])}) $display("[TB] FAIL bub_ctr step %0d: got %0d,%0d want %0d,%0d", i, cx7, cy7, exp_cx[0], exp_cy[0]);
         else n_pass++;
`endif
         if (vld7 === 1'b1) cnt++;
      end
      n_total++;
      if (cnt != 60) $display("[TB] FAIL bub_count: got %0d want 60", cnt);
      else n_pass++;
   endtask

   task automatic test_presof_restart();
      int cnt_fill = 0;
      bit s;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
         n_total++;
         if ({vld7, err7, win7} !== {1'b0, 1'b0, exp_win[0][391:0]}) $display("[TB] FAIL presof step %0d: got vld=%b err=%b win=%h", i, vld7, err7, win7);
         else n_pass++;
      end
      // Mid-frame sof at (5,8), then a sof riding on the restarted frame's last pixel.
      for (int n = 0; n < 133 + 192; n++) begin
         s = (n == 0) || (n == 133) || (n == 133 + 191);
         apply_stimulus(1'b1, 1'b1, s, 1'b0, 8'($urandom));
         n_total++;
         if ({vld9, vld3, vld7} !== exp_vld) $display("[TB] FAIL rst_vld n=%0d: got %b want %b", n, {vld9, vld3, vld7}, exp_vld);
         else n_pass++;
         n_total++;
         if ({done9, done3, done7, err9, err3, err7} !== {{3{exp_done}}, {3{exp_err}}})
            $display("[TB] FAIL rst_pulse n=%0d: got %b want %b", n, {done9, done3, done7, err9, err3, err7}, {{3{exp_done}}, {3{exp_err}}});
         else n_pass++;
         if (win_known[0]) begin
            n_total++;
            if (win7 !== exp_win[0][391:0]) $display("[TB] FAIL rst_win7 n=%0d: got %h want %h", n, win7, exp_win[0][391:0]);
            else n_pass++;
         end
         if (n == 133 || n == 133 + 191) begin
            n_total++;
            if ({err7, done7} !== 2'b10) $display("[TB] FAIL sof_err n=%0d: got err=%b done=%b want 1 0", n, err7, done7);
            else n_pass++;
         end
         if (n >= 133 && n < 133 + 96 && vld7 === 1'b1) cnt_fill++;
      end
      n_total++;
      if (cnt_fill != 0) $display("[TB] FAIL refill_gate: got %0d valid windows want 0", cnt_fill);
      else n_pass++;
   endtask

   task automatic test_ce_freeze();
      // Resume the frame restarted on the last pixel, reach (7,7), then drop ce.
      for (int n = 1; n <= 119; n++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
      n_total++;
      if (vld7 !== 1'b1) $display("[TB] FAIL pre_freeze_vld: got %b want 1", vld7);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
         n_total++;
         if ({vld9, vld3, vld7, done7, err7} !== {exp_vld, exp_done, exp_err})
            $display("[TB] FAIL freeze_flags cyc %0d: got %b want %b", i, {vld9, vld3, vld7, done7, err7}, {exp_vld, exp_done, exp_err});
         else n_pass++;
         n_total++;
         if ({win7, win3} !== {exp_win[0][391:0], exp_win[1][71:0]}) $display("[TB] FAIL freeze_win cyc %0d: got %h", i, win7);
         else n_pass++;
`ifdef FAST_WIN_COORD_EN
         n_total++;
         if ({cx7, cy7} !== {10'(exp_cx[0]), 10'(exp_cy[0])}) $display("[TB] FAIL freeze_ctr cyc %0d: got %0d,%0d", i, cx7, cy7);
         else n_pass++;
`endif
      end
      for (int n = 120; n < 153; n++) begin
         apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
         n_total++;
         if ({vld9, vld3, vld7} !== exp_vld) $display("[TB] FAIL thaw_vld n=%0d: got %b want %b", n, {vld9, vld3, vld7}, exp_vld);
         else n_pass++;
         if (win_known[0]) begin
            n_total++;
            if (win7 !== exp_win[0][391:0]) $display("[TB] FAIL thaw_win7 n=%0d: got %h want %h", n, win7, exp_win[0][391:0]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom));
      n_total++;
      if ({vld9, vld3, vld7, done7, err7, win9, win3, win7} !== '0) $display("[TB] FAIL mid_reset: outputs not cleared, vld=%b", {vld9, vld3, vld7});
      else n_pass++;
`ifdef FAST_WIN_COORD_EN
      n_total++;
      if ({cx7, cy7} !== 20'b0) $display("[TB] FAIL mid_reset_ctr: got %0d,%0d want 0,0", cx7, cy7);
      else n_pass++;
`endif
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b1, 1'b1, (i == 5), 1'b0, 8'($urandom_range(1, 255)));
         n_total++;
         if ({vld7, err7, done7} !== {exp_vld[0], exp_err, exp_done}) $display("[TB] FAIL idle_after_rst %0d: got %b", i, {vld7, err7, done7});
         else n_pass++;
         if (win_known[0]) begin
            n_total++;
            if (win7 !== exp_win[0][391:0]) $display("[TB] FAIL idle_win %0d: got %h want %h", i, win7, exp_win[0][391:0]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bubbles();
      test_presof_restart();
      test_ce_freeze();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
